imm_gen_pipe: RTL

- Pipelined, parametrised immediate generator for the RISC-V decode path.
- Takes full 32-bit instruction words over a valid/ready stream and decodes the format from the opcode.
- Reassembles the scattered immediate fields (I/S/B/U/J) and sign-extends them to XLEN.
- Emits a registered result through a 2-entry skid buffer, giving full throughput and a registered in_ready toward fetch.

---
 rtl/imm_gen_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with 2-entry skid buffer
// Optional illegal-opcode counter: define IMM_GEN_ILLEGAL_CNT_EN to add illegal_cnt/illegal_cnt_clr.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  ,
  input  logic             illegal_cnt_clr,
  output logic [15:0]      illegal_cnt
`endif
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;

  // Skid entry K; the main entry M is the out_* register set itself
  logic             k_valid;
  logic [XLEN-1:0]  k_imm;
  logic [2:0]       k_fmt;
  logic             k_ill;
  logic [TAG_W-1:0] k_tag;

  logic in_fire, out_fire, k_next;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // K stays/becomes occupied only when a word arrives while M is still held
  assign k_next = out_fire ? (k_valid & in_fire)
                           : (out_valid ? (k_valid | in_fire) : k_valid);

  // Opcode decode and immediate reassembly; the sign always comes from instr[31]
  always_comb begin
    dec_imm32 = 32'd0;
    dec_fmt   = FMT_X;
    dec_ill   = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0010111, 7'b0110111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt   = FMT_R;
      end
      default: begin
        dec_fmt   = FMT_X;
        dec_ill   = 1'b1;
      end
    endcase
    dec_imm = XLEN'($signed(dec_imm32));
  end

  // M/K storage: refill M from K on drain, otherwise from the input; spill into K when M is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= 3'd0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      k_valid     <= 1'b0;
      k_imm       <= '0;
      k_fmt       <= 3'd0;
      k_ill       <= 1'b0;
      k_tag       <= '0;
      in_ready    <= 1'b1;
    end else begin
      if (out_fire && k_valid) begin
        out_imm     <= k_imm;
        out_fmt     <= k_fmt;
        out_illegal <= k_ill;
        out_tag     <= k_tag;
        if (in_fire) begin
          k_imm <= dec_imm;
          k_fmt <= dec_fmt;
          k_ill <= dec_ill;
          k_tag <= in_tag;
        end
      end else if (out_fire || !out_valid) begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_illegal <= dec_ill;
          out_tag     <= in_tag;
        end
      end else if (in_fire) begin
        k_imm <= dec_imm;
        k_fmt <= dec_fmt;
        k_ill <= dec_ill;
        k_tag <= in_tag;
      end
      k_valid  <= k_next;
      in_ready <= ~k_next;
    end
  end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  // Saturating count of illegal words leaving the block; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= 16'd0;
    end else if (illegal_cnt_clr) begin
      illegal_cnt <= 16'd0;
    end else if (out_fire && out_illegal && illegal_cnt != 16'hFFFF) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule
